// File: rtl/flat_array_serializer_if.sv
// Stream bundle between a flat-array producer, the serializer and a narrow
// element consumer. The serializer connects through the slave modport; the
// surrounding environment (producer plus consumer) uses the master modport.
interface flat_array_serializer_if #(
  parameter int BIT_WIDTH = 4,
  parameter int ROWS      = 8,
  parameter int COLS      = 8
);
  localparam int N  = ROWS * COLS;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

  logic [N*BIT_WIDTH-1:0] in_data;
  logic                   in_valid;
  logic                   in_ready;
  logic [BIT_WIDTH-1:0]   out_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [RW-1:0]          out_row;
  logic [CW-1:0]          out_col;
  logic                   out_last;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_row, out_col, out_last
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_row, out_col, out_last
  );
endinterface

// File: rtl/flat_array_serializer.sv
// Serializes one flat ROWS*COLS array word into single elements, row index
// fastest, each tagged with its row/column and a last flag. A new word can be
// taken on the last beat of the previous one, so streaming has no bubbles.
module flat_array_serializer #(
  parameter int BIT_WIDTH = 4,
  parameter int ROWS      = 8,
  parameter int COLS      = 8
) (
  input logic                    clk,
  input logic                    rst,
  flat_array_serializer_if.slave bus
);
  localparam int N  = ROWS * COLS;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

  localparam logic [RW-1:0] ROW_MAX = RW'(ROWS - 1);
  localparam logic [CW-1:0] COL_MAX = CW'(COLS - 1);

  typedef enum logic [0:0] {
    IDLE,
    STREAM
  } state_t;

  state_t                 state;
  state_t                 next_state;
  logic [N*BIT_WIDTH-1:0] shreg;
  logic [RW-1:0]          row;
  logic [CW-1:0]          col;
  logic                   out_valid;
  logic                   out_last;
  logic                   in_ready;
  logic                   fire_in;
  logic                   fire_out;

  // State register; reset abandons any partially emitted word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Handshake decode and next state; a last beat doubles as an input slot.
  always_comb begin
    out_valid  = 1'b0;
    out_last   = 1'b0;
    in_ready   = 1'b0;
    fire_in    = 1'b0;
    fire_out   = 1'b0;
    next_state = state;

    out_valid = (state == STREAM);
    out_last  = out_valid && (row == ROW_MAX) && (col == COL_MAX);
    fire_out  = out_valid && bus.out_ready;
    in_ready  = (state == IDLE) || (fire_out && out_last);
    fire_in   = bus.in_valid && in_ready;

    if (fire_in) begin
      next_state = STREAM;
    end else if (fire_out && out_last) begin
      next_state = IDLE;
    end
  end

  // Element shift register and row/column counters; the lowest element is
  // always the one on display, and indices return to zero after the last beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg <= '0;
      row   <= '0;
      col   <= '0;
    end else if (fire_in) begin
      shreg <= bus.in_data;
      row   <= '0;
      col   <= '0;
    end else if (fire_out) begin
      shreg <= shreg >> BIT_WIDTH;
      if (out_last) begin
        row <= '0;
        col <= '0;
      end else if (row == ROW_MAX) begin
        row <= '0;
        col <= col + CW'(1);
      end else begin
        row <= row + RW'(1);
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_last  = out_last;
  assign bus.out_data  = shreg[BIT_WIDTH-1:0];
  assign bus.out_row   = row;
  assign bus.out_col   = col;
endmodule

// File: tb/tb_flat_array_serializer.sv
// Directed bench for flat_array_serializer: a 2x2 instance for the main
// stream, stall, back-to-back and reset scenarios, plus 1x3 and 1x1 instances.
module tb_flat_array_serializer;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  flat_array_serializer_if #(.BIT_WIDTH(4), .ROWS(2), .COLS(2)) ifa ();
  flat_array_serializer_if #(.BIT_WIDTH(4), .ROWS(1), .COLS(3)) ifb ();
  flat_array_serializer_if #(.BIT_WIDTH(4), .ROWS(1), .COLS(1)) ifc ();

  flat_array_serializer #(.BIT_WIDTH(4), .ROWS(2), .COLS(2)) dut_a (
    .clk(clk), .rst(rst), .bus(ifa)
  );
  flat_array_serializer #(.BIT_WIDTH(4), .ROWS(1), .COLS(3)) dut_b (
    .clk(clk), .rst(rst), .bus(ifb)
  );
  flat_array_serializer #(.BIT_WIDTH(4), .ROWS(1), .COLS(1)) dut_c (
    .clk(clk), .rst(rst), .bus(ifc)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard time limit so the run can never hang.
  initial begin
    #100000;
    $display("[TB] FAIL timeout reached");
    $fatal(1, "[TB] timeout");
  end

  task automatic test_reset();
    rst = 1'b1;
    ifa.in_data = '0; ifa.in_valid = 1'b0; ifa.out_ready = 1'b0;
    ifb.in_data = '0; ifb.in_valid = 1'b0; ifb.out_ready = 1'b0;
    ifc.in_data = '0; ifc.in_valid = 1'b0; ifc.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (ifa.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid got %b expected 0", ifa.out_valid); end
    checks++; if (ifa.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready got %b expected 1", ifa.in_ready); end
    checks++; if (ifa.out_data !== 4'h0) begin errors++; $display("[TB] FAIL reset_out_data got %h expected 0", ifa.out_data); end
    checks++; if (ifa.out_row !== 1'b0 || ifa.out_col !== 1'b0) begin errors++; $display("[TB] FAIL reset_index got %0d,%0d expected 0,0", ifa.out_row, ifa.out_col); end
    checks++; if (ifa.out_last !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_last got %b expected 0", ifa.out_last); end
    checks++; if (ifc.out_last !== 1'b0 || ifc.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_single got last=%b valid=%b expected 0,0", ifc.out_last, ifc.out_valid); end
    checks++; if (ifb.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_b_in_ready got %b expected 1", ifb.in_ready); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [3:0] exp_d [4] = '{4'hA, 4'hB, 4'hC, 4'hD};
    logic       exp_r [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic       exp_c [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    @(negedge clk);
    ifa.in_data = 16'hDCBA; ifa.in_valid = 1'b1; ifa.out_ready = 1'b1;
    #1;
    checks++; if (ifa.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL basic_accept got %b expected 1", ifa.in_ready); end
    @(negedge clk);
    ifa.in_valid = 1'b0; ifa.in_data = 16'h5555;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      checks++; if (ifa.out_valid !== 1'b1) begin errors++; $display("[TB] FAIL basic_valid[%0d] got %b expected 1", i, ifa.out_valid); end
      checks++; if (ifa.out_data !== exp_d[i]) begin errors++; $display("[TB] FAIL basic_data[%0d] got %h expected %h", i, ifa.out_data, exp_d[i]); end
      checks++; if (ifa.out_row !== exp_r[i] || ifa.out_col !== exp_c[i]) begin errors++; $display("[TB] FAIL basic_index[%0d] got %0d,%0d expected %0d,%0d", i, ifa.out_row, ifa.out_col, exp_r[i], exp_c[i]); end
      checks++; if (ifa.out_last !== (i == 3)) begin errors++; $display("[TB] FAIL basic_last[%0d] got %b expected %b", i, ifa.out_last, (i == 3)); end
      checks++; if (ifa.in_ready !== (i == 3)) begin errors++; $display("[TB] FAIL basic_in_ready[%0d] got %b expected %b", i, ifa.in_ready, (i == 3)); end
    end
    @(negedge clk);
    #1;
    checks++; if (ifa.out_valid !== 1'b0 || ifa.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL basic_idle got valid=%b ready=%b expected 0,1", ifa.out_valid, ifa.in_ready); end
  endtask

  task automatic test_stall();
    logic [3:0] exp_d [4] = '{4'hA, 4'hB, 4'hC, 4'hD};
    logic       seq [7]   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    int idx = 0;
    @(negedge clk);
    ifa.in_data = 16'hDCBA; ifa.in_valid = 1'b1; ifa.out_ready = 1'b1;
    @(negedge clk);
    ifa.in_valid = 1'b0;
    for (int c = 0; c < 7; c++) begin
      if (c > 0) @(negedge clk);
      ifa.out_ready = seq[c];
      #1;
      checks++; if (ifa.out_valid !== 1'b1 || ifa.out_data !== exp_d[idx]) begin errors++; $display("[TB] FAIL stall_data[%0d] got valid=%b data=%h expected 1,%h", c, ifa.out_valid, ifa.out_data, exp_d[idx]); end
      checks++; if (ifa.in_ready !== (seq[c] && idx == 3)) begin errors++; $display("[TB] FAIL stall_in_ready[%0d] got %b expected %b", c, ifa.in_ready, (seq[c] && idx == 3)); end
      if (seq[c]) idx++;
    end
    @(negedge clk);
    ifa.out_ready = 1'b1;
    #1;
    checks++; if (ifa.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL stall_done got valid=%b expected 0 after %0d beats", ifa.out_valid, idx); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_d [8] = '{4'hA, 4'hB, 4'hC, 4'hD, 4'h0, 4'h1, 4'h2, 4'h3};
    @(negedge clk);
    ifa.in_data = 16'hDCBA; ifa.in_valid = 1'b1; ifa.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 3) ifa.in_data = 16'h3210;
      if (i == 4) ifa.in_valid = 1'b0;
      #1;
      checks++; if (ifa.out_valid !== 1'b1 || ifa.out_data !== exp_d[i]) begin errors++; $display("[TB] FAIL b2b_data[%0d] got valid=%b data=%h expected 1,%h", i, ifa.out_valid, ifa.out_data, exp_d[i]); end
      checks++; if (ifa.in_ready !== (i == 3 || i == 7)) begin errors++; $display("[TB] FAIL b2b_in_ready[%0d] got %b expected %b", i, ifa.in_ready, (i == 3 || i == 7)); end
    end
    @(negedge clk);
    #1;
    checks++; if (ifa.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_idle got %b expected 0", ifa.out_valid); end
  endtask

  task automatic test_reset_mid();
    logic [3:0] exp_d [4] = '{4'h4, 4'h5, 4'h6, 4'h7};
    logic       exp_r [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic       exp_c [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    @(negedge clk);
    ifa.in_data = 16'hDCBA; ifa.in_valid = 1'b1; ifa.out_ready = 1'b1;
    @(negedge clk);
    ifa.in_valid = 1'b0;
    #1;
    checks++; if (ifa.out_data !== 4'hA) begin errors++; $display("[TB] FAIL rstmid_a got %h expected a", ifa.out_data); end
    @(negedge clk);
    #1;
    checks++; if (ifa.out_data !== 4'hB) begin errors++; $display("[TB] FAIL rstmid_b got %h expected b", ifa.out_data); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (ifa.out_valid !== 1'b0 || ifa.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_async got valid=%b ready=%b expected 0,1", ifa.out_valid, ifa.in_ready); end
    checks++; if (ifa.out_row !== 1'b0 || ifa.out_col !== 1'b0 || ifa.out_data !== 4'h0) begin errors++; $display("[TB] FAIL rstmid_clear got row=%0d col=%0d data=%h expected 0,0,0", ifa.out_row, ifa.out_col, ifa.out_data); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (ifa.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_quiet got %b expected 0", ifa.out_valid); end
    ifa.in_data = 16'h7654; ifa.in_valid = 1'b1;
    @(negedge clk);
    ifa.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      checks++; if (ifa.out_valid !== 1'b1 || ifa.out_data !== exp_d[i]) begin errors++; $display("[TB] FAIL rstmid_data[%0d] got valid=%b data=%h expected 1,%h", i, ifa.out_valid, ifa.out_data, exp_d[i]); end
      checks++; if (ifa.out_row !== exp_r[i] || ifa.out_col !== exp_c[i]) begin errors++; $display("[TB] FAIL rstmid_index[%0d] got %0d,%0d expected %0d,%0d", i, ifa.out_row, ifa.out_col, exp_r[i], exp_c[i]); end
    end
    @(negedge clk);
  endtask

  task automatic test_degenerate();
    logic [3:0] exp_d [3] = '{4'h7, 4'h8, 4'h9};
    logic [1:0] exp_c [3] = '{2'd0, 2'd1, 2'd2};
    @(negedge clk);
    ifb.in_data = 12'h987; ifb.in_valid = 1'b1; ifb.out_ready = 1'b1;
    @(negedge clk);
    ifb.in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      checks++; if (ifb.out_valid !== 1'b1 || ifb.out_data !== exp_d[i]) begin errors++; $display("[TB] FAIL degen_data[%0d] got valid=%b data=%h expected 1,%h", i, ifb.out_valid, ifb.out_data, exp_d[i]); end
      checks++; if (ifb.out_row !== 1'b0 || ifb.out_col !== exp_c[i]) begin errors++; $display("[TB] FAIL degen_index[%0d] got %0d,%0d expected 0,%0d", i, ifb.out_row, ifb.out_col, exp_c[i]); end
      checks++; if (ifb.out_last !== (i == 2)) begin errors++; $display("[TB] FAIL degen_last[%0d] got %b expected %b", i, ifb.out_last, (i == 2)); end
    end
    @(negedge clk);
    #1;
    checks++; if (ifb.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL degen_idle got %b expected 0", ifb.out_valid); end
  endtask

  task automatic test_single();
    logic [3:0] vals [3] = '{4'h5, 4'h6, 4'h7};
    @(negedge clk);
    ifc.in_data = vals[0]; ifc.in_valid = 1'b1; ifc.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i < 2) ifc.in_data = vals[i+1];
      else ifc.in_valid = 1'b0;
      #1;
      checks++; if (ifc.out_valid !== 1'b1 || ifc.out_data !== vals[i]) begin errors++; $display("[TB] FAIL single_data[%0d] got valid=%b data=%h expected 1,%h", i, ifc.out_valid, ifc.out_data, vals[i]); end
      checks++; if (ifc.out_last !== 1'b1 || ifc.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL single_last[%0d] got last=%b ready=%b expected 1,1", i, ifc.out_last, ifc.in_ready); end
    end
    @(negedge clk);
    #1;
    checks++; if (ifc.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL single_idle got %b expected 0", ifc.out_valid); end
  endtask

  // Scenario sequence followed by the summary line.
  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    test_reset();
    test_basic();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    test_degenerate();
    test_single();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
